// File: rtl/game_pkg.sv
// ---------------------------------------------------------------------------
// game_pkg : shared types, start speed and 16x16 splash frames
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package game_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      OVER = 2'd2
   } state_t;

   typedef logic [15:0][15:0] frame_t;

   localparam logic [2:0] START_SPEED = 3'd0;

   // Row 15 is the leftmost element of each concatenation, row 0 the rightmost
   localparam frame_t START_R = {16'hFFFF, {14{16'h8001}}, 16'hFFFF};
   localparam frame_t START_G = {{4{16'h0000}}, {8{16'h0FF0}}, {4{16'h0000}}};
   localparam frame_t END_R   = {8{16'hFF00, 16'h00FF}};
   localparam frame_t END_G   = {16{16'h1818}};

   function automatic logic [2:0] sat_inc3(input logic [2:0] v);
      return (v == 3'd7) ? v : v + 3'd1;
   endfunction

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/game_controller_edge_detect.sv
// ---------------------------------------------------------------------------
// edge_detect : rising-edge detector on an already-synchronised input
// Revision    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module edge_detect (
   input  logic clk,
   input  logic rst,
   input  logic i_din,
   output logic o_rise
);

   logic r_prev;

   always_ff @(posedge clk) begin
      if (rst) r_prev <= 1'b0;
      else     r_prev <= i_din;
   end

   assign o_rise = i_din & ~r_prev;

endmodule

`default_nettype wire

// File: rtl/game_controller.sv
// ---------------------------------------------------------------------------
// game_controller : IDLE/RUN/OVER sequencer, speed/score keeping, frame mux
// Optional macro SCORE_DISPLAY_EN overlays the score on the end screen.
// Revision        : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module game_controller
   import game_pkg::*;
#(
   parameter int LEVEL_TICKS = 1000,
   parameter int SCORE_TICKS = 250,
   parameter int HOLD_TICKS  = 500
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              L,
   input  logic              R,
   input  logic              ENDen,
   input  logic [15:0][15:0] RPixRUN,
   input  logic [15:0][15:0] GPixRUN,
   output logic              RUNen,
   output logic [2:0]        scrollSpeed,
   output logic [15:0][15:0] RPixOut,
   output logic [15:0][15:0] GPixOut,
   output logic [7:0]        score
);

   localparam int LVL_W  = (LEVEL_TICKS > 1) ? $clog2(LEVEL_TICKS) : 1;
   localparam int SCR_W  = (SCORE_TICKS > 1) ? $clog2(SCORE_TICKS) : 1;
   localparam int HOLD_W = $clog2(HOLD_TICKS + 1);

   state_t             r_state,    w_state_nxt;
   logic [2:0]         r_speed,    w_speed_nxt;
   logic [7:0]         r_score,    w_score_nxt;
   logic [LVL_W-1:0]   r_lvl_cnt,  w_lvl_cnt_nxt;
   logic [SCR_W-1:0]   r_scr_cnt,  w_scr_cnt_nxt;
   logic [HOLD_W-1:0]  r_hold_cnt, w_hold_cnt_nxt;
   frame_t             r_frz_r,    w_frz_r_nxt;
   frame_t             r_frz_g,    w_frz_g_nxt;

   logic   w_rise_l;
   logic   w_rise_r;
   logic   w_hold_done;
   frame_t w_end_g;

   edge_detect u_edge_l (
      .clk    (CLK),
      .rst    (RST),
      .i_din  (L),
      .o_rise (w_rise_l)
   );

   edge_detect u_edge_r (
      .clk    (CLK),
      .rst    (RST),
      .i_din  (R),
      .o_rise (w_rise_r)
   );

   // Counter sits at HOLD_TICKS once the frozen frame has had its full showing
   assign w_hold_done = (r_hold_cnt == HOLD_W'(HOLD_TICKS));

`ifdef SCORE_DISPLAY_EN
   assign w_end_g = {END_G[15:1], {8'h00, r_score}};
`else
   assign w_end_g = END_G;
`endif

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state    <= IDLE;
         r_speed    <= START_SPEED;
         r_score    <= 8'd0;
         r_lvl_cnt  <= '0;
         r_scr_cnt  <= '0;
         r_hold_cnt <= '0;
         r_frz_r    <= '0;
         r_frz_g    <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_speed    <= w_speed_nxt;
         r_score    <= w_score_nxt;
         r_lvl_cnt  <= w_lvl_cnt_nxt;
         r_scr_cnt  <= w_scr_cnt_nxt;
         r_hold_cnt <= w_hold_cnt_nxt;
         r_frz_r    <= w_frz_r_nxt;
         r_frz_g    <= w_frz_g_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_speed_nxt    = r_speed;
      w_score_nxt    = r_score;
      w_lvl_cnt_nxt  = r_lvl_cnt;
      w_scr_cnt_nxt  = r_scr_cnt;
      w_hold_cnt_nxt = '0;
      w_frz_r_nxt    = r_frz_r;
      w_frz_g_nxt    = r_frz_g;

      case (r_state)
         IDLE: begin
            if (w_rise_l || w_rise_r) begin
               w_state_nxt   = RUN;
               w_score_nxt   = 8'd0;
               w_speed_nxt   = START_SPEED;
               w_lvl_cnt_nxt = '0;
               w_scr_cnt_nxt = '0;
            end
         end

         RUN: begin
            if (ENDen) begin
               // Collision wins: freeze this frame and drop any tick due now
               w_state_nxt = OVER;
               w_frz_r_nxt = RPixRUN;
               w_frz_g_nxt = GPixRUN;
            end else begin
               if (r_lvl_cnt == LVL_W'(LEVEL_TICKS - 1)) begin
                  w_lvl_cnt_nxt = '0;
                  w_speed_nxt   = sat_inc3(r_speed);
               end else begin
                  w_lvl_cnt_nxt = r_lvl_cnt + LVL_W'(1);
               end
               if (r_scr_cnt == SCR_W'(SCORE_TICKS - 1)) begin
                  w_scr_cnt_nxt = '0;
                  w_score_nxt   = sat_inc8(r_score);
               end else begin
                  w_scr_cnt_nxt = r_scr_cnt + SCR_W'(1);
               end
            end
         end

         OVER: begin
            if (!w_hold_done) begin
               w_hold_cnt_nxt = r_hold_cnt + HOLD_W'(1);
            end else begin
               w_hold_cnt_nxt = r_hold_cnt;
               if (L && R && (w_rise_l || w_rise_r)) w_state_nxt = IDLE;
            end
         end

         default: w_state_nxt = IDLE;
      endcase
   end

   always_comb begin
      RUNen       = (r_state == RUN);
      scrollSpeed = r_speed;
      score       = r_score;
      RPixOut     = START_R;
      GPixOut     = START_G;
      case (r_state)
         RUN: begin
            RPixOut = RPixRUN;
            GPixOut = GPixRUN;
         end
         OVER: begin
            if (w_hold_done) begin
               RPixOut = END_R;
               GPixOut = w_end_g;
            end else begin
               RPixOut = r_frz_r;
               GPixOut = r_frz_g;
            end
         end
         default: ;
      endcase
   end

endmodule

`default_nettype wire

// File: tb/tb_game_controller.sv
// ---------------------------------------------------------------------------
// tb_game_controller : table-driven directed bench for game_controller
// Revision           : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_game_controller;

   typedef logic [15:0][15:0] frm_t;

   localparam frm_t C_START_R = {16'hFFFF, {14{16'h8001}}, 16'hFFFF};
   localparam frm_t C_START_G = {{4{16'h0000}}, {8{16'h0FF0}}, {4{16'h0000}}};
   localparam frm_t C_END_R   = {8{16'hFF00, 16'h00FF}};
   localparam frm_t C_END_G   = {16{16'h1818}};

   localparam int K_START = 0;
   localparam int K_LIVE  = 1;
   localparam int K_FROZ  = 2;
   localparam int K_END   = 3;
   localparam int NV      = 23;

   typedef struct {
      logic        rs;
      logic        l;
      logic        r;
      logic        en;
      int          n;
      logic [15:0] row;
      logic        e_run;
      logic [2:0]  e_sp;
      logic [7:0]  e_sc;
      int          kind;
      logic [15:0] frz;
   } vec_t;

   logic        CLK;
   logic        RST;
   logic        L;
   logic        R;
   logic        ENDen;
   frm_t        RPixRUN;
   frm_t        GPixRUN;
   logic        RUNen;
   logic [2:0]  scrollSpeed;
   frm_t        RPixOut;
   frm_t        GPixOut;
   logic [7:0]  score;

   int   checks;
   int   errors;
   vec_t tv [NV];

   game_controller #(
      .LEVEL_TICKS (4),
      .SCORE_TICKS (3),
      .HOLD_TICKS  (8)
   ) dut (
      .CLK         (CLK),
      .RST         (RST),
      .L           (L),
      .R           (R),
      .ENDen       (ENDen),
      .RPixRUN     (RPixRUN),
      .GPixRUN     (GPixRUN),
      .RUNen       (RUNen),
      .scrollSpeed (scrollSpeed),
      .RPixOut     (RPixOut),
      .GPixOut     (GPixOut),
      .score       (score)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   function automatic frm_t mk_r(input logic [15:0] row);
      frm_t f;
      f    = '0;
      f[3] = row;
      return f;
   endfunction

   function automatic frm_t mk_g(input logic [15:0] row);
      frm_t f;
      f    = '0;
      f[7] = row ^ 16'h5A5A;
      return f;
   endfunction

   function automatic frm_t end_g(input logic [7:0] sc);
      frm_t f;
      f = C_END_G;
`ifdef SCORE_DISPLAY_EN
      f[0] = {8'h00, sc};
`else
      f[0] = C_END_G[0] | {8'h00, sc & 8'h00};
`endif
      return f;
   endfunction

   function automatic frm_t exp_r(input int kind, input logic [15:0] row, input logic [15:0] frz);
      case (kind)
         K_LIVE:  return mk_r(row);
         K_FROZ:  return mk_r(frz);
         K_END:   return C_END_R;
         default: return C_START_R;
      endcase
   endfunction

   function automatic frm_t exp_g(input int kind, input logic [15:0] row, input logic [15:0] frz,
                                  input logic [7:0] sc);
      case (kind)
         K_LIVE:  return mk_g(row);
         K_FROZ:  return mk_g(frz);
         K_END:   return end_g(sc);
         default: return C_START_G;
      endcase
   endfunction

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         errors = errors + 1;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic step(input logic rs, input logic l, input logic r, input logic en,
                       input logic [15:0] row);
      RST     = rs;
      L       = l;
      R       = r;
      ENDen   = en;
      RPixRUN = mk_r(row);
      GPixRUN = mk_g(row);
      @(posedge CLK);
      #1;
   endtask

   initial begin
      checks  = 0;
      errors  = 0;
      RST     = 1'b1;
      L       = 1'b0;
      R       = 1'b0;
      ENDen   = 1'b0;
      RPixRUN = '0;
      GPixRUN = '0;

      //        rs  l  r  en  n   row       run sp sc  kind     frz
      tv[0]  = '{1, 0, 0, 0,  2, 16'h0000, 0, 0, 0,   K_START, 16'h0};
      tv[1]  = '{0, 0, 0, 0,  1, 16'h0000, 0, 0, 0,   K_START, 16'h0};
      tv[2]  = '{0, 1, 0, 0,  1, 16'hFFFF, 1, 0, 0,   K_LIVE,  16'h0};
      tv[3]  = '{0, 0, 0, 0,  1, 16'h1234, 1, 0, 0,   K_LIVE,  16'h0};
      tv[4]  = '{0, 0, 0, 0,  2, 16'h0F0F, 1, 0, 1,   K_LIVE,  16'h0};
      tv[5]  = '{0, 0, 0, 0,  1, 16'h0F0F, 1, 1, 1,   K_LIVE,  16'h0};
      tv[6]  = '{0, 1, 1, 0,  2, 16'h8421, 1, 1, 2,   K_LIVE,  16'h0};
      tv[7]  = '{0, 0, 0, 0,  2, 16'h8421, 1, 2, 2,   K_LIVE,  16'h0};
      tv[8]  = '{0, 0, 0, 0,  4, 16'h00F0, 1, 3, 4,   K_LIVE,  16'h0};
      tv[9]  = '{0, 0, 0, 0, 16, 16'h00F0, 1, 7, 9,   K_LIVE,  16'h0};
      tv[10] = '{0, 0, 0, 0, 12, 16'h7777, 1, 7, 13,  K_LIVE,  16'h0};
      tv[11] = '{1, 0, 0, 0,  2, 16'h7777, 0, 0, 0,   K_START, 16'h0};
      tv[12] = '{0, 0, 0, 1,  1, 16'h7777, 0, 0, 0,   K_START, 16'h0};
      tv[13] = '{0, 0, 1, 0,  1, 16'h00FF, 1, 0, 0,   K_LIVE,  16'h0};
      tv[14] = '{0, 0, 0, 0, 11, 16'h0FF0, 1, 2, 3,   K_LIVE,  16'h0};
      tv[15] = '{0, 0, 0, 1,  1, 16'hBEEF, 0, 2, 3,   K_FROZ,  16'hBEEF};
      tv[16] = '{0, 0, 0, 0,  3, 16'h1111, 0, 2, 3,   K_FROZ,  16'hBEEF};
      tv[17] = '{0, 1, 1, 0,  1, 16'h1111, 0, 2, 3,   K_FROZ,  16'hBEEF};
      tv[18] = '{0, 1, 1, 1,  3, 16'h2222, 0, 2, 3,   K_FROZ,  16'hBEEF};
      tv[19] = '{0, 1, 1, 0,  1, 16'h2222, 0, 2, 3,   K_END,   16'h0};
      tv[20] = '{0, 0, 0, 0,  1, 16'h2222, 0, 2, 3,   K_END,   16'h0};
      tv[21] = '{0, 1, 0, 0,  1, 16'h2222, 0, 2, 3,   K_END,   16'h0};
      tv[22] = '{0, 1, 1, 0,  1, 16'h2222, 0, 2, 3,   K_START, 16'h0};

      for (int i = 0; i < NV; i++) begin
         for (int k = 0; k < tv[i].n; k++)
            step(tv[i].rs, tv[i].l, tv[i].r, tv[i].en, tv[i].row);
         chk($sformatf("v%0d RUNen", i), RUNen, tv[i].e_run);
         chk($sformatf("v%0d scrollSpeed", i), scrollSpeed, tv[i].e_sp);
         chk($sformatf("v%0d score", i), score, tv[i].e_sc);
         chk($sformatf("v%0d RPixOut", i), RPixOut, exp_r(tv[i].kind, tv[i].row, tv[i].frz));
         chk($sformatf("v%0d GPixOut", i), GPixOut,
             exp_g(tv[i].kind, tv[i].row, tv[i].frz, tv[i].e_sc));
      end

      // Long run to score 0xA5, then collide and inspect the end screen
      step(0, 0, 0, 0, 16'h0);
      step(0, 1, 0, 0, 16'h0);
      chk("rerun RUNen", RUNen, 1'b1);
      chk("rerun score cleared", score, 8'd0);
      chk("rerun speed cleared", scrollSpeed, 3'd0);
      for (int k = 0; k < 495; k++) step(0, 0, 0, 0, 16'h0);
      chk("score A5", score, 8'hA5);
      chk("speed sat", scrollSpeed, 3'd7);
      step(0, 0, 0, 1, 16'hCAFE);
      chk("A5 frozen R", RPixOut, mk_r(16'hCAFE));
      for (int k = 0; k < 8; k++) step(0, 0, 0, 0, 16'h0);
      chk("A5 end R", RPixOut, C_END_R);
`ifdef SCORE_DISPLAY_EN
      chk("A5 G row0", GPixOut[0], 16'h00A5);
`else
      chk("A5 G row0", GPixOut[0], 16'h1818);
`endif
      chk("A5 end G", GPixOut, end_g(8'hA5));
      chk("A5 score held", score, 8'hA5);

      // Restart and run long enough to saturate the score
      step(0, 1, 1, 0, 16'h0);
      chk("restart RUNen", RUNen, 1'b0);
      chk("restart R", RPixOut, C_START_R);
      step(0, 0, 0, 0, 16'h0);
      step(0, 1, 0, 0, 16'h0);
      for (int k = 0; k < 800; k++) step(0, 0, 0, 0, 16'h0);
      chk("score sat", score, 8'hFF);
      chk("speed sat2", scrollSpeed, 3'd7);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
